// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous pulse train.
// Optional glitch filter on the synchronized input: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int W          = 20,
    parameter int TIMEOUT    = 1000000,
    parameter int FILTER_LEN = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pwm_in,
    output logic         valid,
    output logic [W-1:0] high_cycles,
    output logic [W-1:0] period_cycles,
    output logic         stuck_high,
    output logic         stuck_low
);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    localparam logic [W-1:0] TMO = W'(TIMEOUT);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT must be at least 2");
    end
    if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_filter
        $error("pwm_capture: FILTER_LEN must be in 2..255");
    end

    state_t       state_q;
    state_t       state_d;
    logic         s1;
    logic         s2;
    logic         s3;
    logic         lvl;
    logic         rise;
    logic         fall;
    logic [W-1:0] cnt;
    logic [W-1:0] hi_latch;
    logic         tmo_hit;
    logic         cap;
    logic         lat;
    logic         tmo;

`ifdef PWM_CAPTURE_FILTER_EN
    logic       flt;
    logic [7:0] fcnt;

    // Level only follows s2 after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            flt  <= 1'b0;
            fcnt <= 8'd0;
        end else if (s2 == flt) begin
            fcnt <= 8'd0;
        end else if (fcnt == 8'(FILTER_LEN - 1)) begin
            flt  <= s2;
            fcnt <= 8'd0;
        end else begin
            fcnt <= fcnt + 8'd1;
        end
    end

    assign lvl = flt;
`else
    assign lvl = s2;
`endif

    assign rise    = lvl & ~s3;
    assign fall    = ~lvl & s3;
    assign tmo_hit = (cnt == TMO) && !rise && !fall;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_RISE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus capture, latch and timeout decisions.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        lat     = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (tmo_hit) begin
                    tmo = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    lat     = 1'b1;
                    state_d = LOW;
                end else if (rise) begin
                    cap     = 1'b1;
                    state_d = HIGH;
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = WAIT_RISE;
                end
            end
            LOW: begin
                if (rise) begin
                    cap     = 1'b1;
                    state_d = HIGH;
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = WAIT_RISE;
                end
            end
            default: state_d = WAIT_RISE;
        endcase
    end

    // Synchronizer, cycle counter, measurement and stuck-flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            cnt           <= '0;
            hi_latch      <= '0;
            valid         <= 1'b0;
            high_cycles   <= '0;
            period_cycles <= '0;
            stuck_high    <= 1'b0;
            stuck_low     <= 1'b0;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            s3    <= lvl;
            cnt   <= rise ? W'(1) : cnt + W'(1);
            valid <= cap;
            if (lat) begin
                hi_latch <= cnt;
            end
            if (cap) begin
                high_cycles   <= hi_latch;
                period_cycles <= cnt;
            end
            if (rise || fall) begin
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end else if (tmo) begin
                stuck_high <= lvl;
                stuck_low  <= ~lvl;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed table plus corner-case sequences for pwm_capture.
// Valid strobes are logged by a monitor and checked against constants.
module tb_pwm_capture;

    localparam int W = 20;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         pwm_in = 1'b0;
    logic         valid;
    logic [W-1:0] high_cycles;
    logic [W-1:0] period_cycles;
    logic         stuck_high;
    logic         stuck_low;

    pwm_capture #(
        .W(W),
        .TIMEOUT(64),
        .FILTER_LEN(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pwm_in(pwm_in),
        .valid(valid),
        .high_cycles(high_cycles),
        .period_cycles(period_cycles),
        .stuck_high(stuck_high),
        .stuck_low(stuck_low)
    );

    always #5 clock = ~clock;

    typedef struct {
        int hi;
        int lo;
        int exp_hi;
        int exp_per;
    } vec_t;

    vec_t tbl[6];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   lg_hi[$];
    int   lg_per[$];
    int   lg_cyc[$];
    logic prev_v = 1'b0;

    // Log every valid strobe with its cycle number; valid must never repeat.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (valid === 1'b1) begin
            lg_hi.push_back(int'(high_cycles));
            lg_per.push_back(int'(period_cycles));
            lg_cyc.push_back(cyc);
            n_chk++;
            if (prev_v === 1'b1) begin
                n_fail++;
                $display("FAIL valid_back_to_back: valid high at cycle %0d and %0d, required gap >= 2",
                         cyc - 1, cyc);
            end
        end
        prev_v = valid;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic wave(input int hi, input int lo);
        pwm_in = 1'b1;
        repeat (hi) @(negedge clock);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clock);
    endtask

    task automatic clear_log();
        lg_hi.delete();
        lg_per.delete();
        lg_cyc.delete();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(valid), 0);
        chk({nm, "_high"}, 32'(high_cycles), 0);
        chk({nm, "_period"}, 32'(period_cycles), 0);
        chk({nm, "_stuck_high"}, 32'(stuck_high), 0);
        chk({nm, "_stuck_low"}, 32'(stuck_low), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        pwm_in = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;
        clear_log();
    endtask

    initial begin
        int vc;
        int guard;

        tbl[0] = '{3, 7, 3, 10};
        tbl[1] = '{1, 9, 1, 10};
        tbl[2] = '{5, 5, 5, 10};
        tbl[3] = '{9, 1, 9, 10};
        tbl[4] = '{1, 1, 1, 2};
        tbl[5] = '{19, 1, 19, 20};

        // Periodic waveforms: 5 rises give 4 valids spaced one period.
        for (int i = 0; i < 6; i++) begin
`ifdef PWM_CAPTURE_FILTER_EN
            if (tbl[i].hi < 4 || tbl[i].lo < 4) continue;
`endif
            do_reset();
            repeat (4) wave(tbl[i].hi, tbl[i].lo);
            pwm_in = 1'b1;
            repeat (6) @(negedge clock);
            pwm_in = 1'b0;
            chk($sformatf("tbl%0d_count", i), lg_hi.size(), 4);
            for (int k = 0; k < lg_hi.size() && k < 4; k++) begin
                chk($sformatf("tbl%0d_hi%0d", i, k), lg_hi[k],
                    tbl[i].exp_hi);
                chk($sformatf("tbl%0d_per%0d", i, k), lg_per[k],
                    tbl[i].exp_per);
                if (k > 0) begin
                    chk($sformatf("tbl%0d_gap%0d", i, k),
                        lg_cyc[k] - lg_cyc[k-1], tbl[i].exp_per);
                end
            end
            chk($sformatf("tbl%0d_stuck_high", i), 32'(stuck_high), 0);
            chk($sformatf("tbl%0d_stuck_low", i), 32'(stuck_low), 0);
        end

`ifndef PWM_CAPTURE_FILTER_EN
        // Duty sweep 1/20 .. 19/20, one period each.
        do_reset();
        for (int h = 1; h <= 19; h++) wave(h, 20 - h);
        pwm_in = 1'b1;
        repeat (6) @(negedge clock);
        pwm_in = 1'b0;
        chk("sweep_count", lg_hi.size(), 19);
        for (int k = 0; k < lg_hi.size() && k < 19; k++) begin
            chk($sformatf("sweep_hi%0d", k), lg_hi[k], k + 1);
            chk($sformatf("sweep_per%0d", k), lg_per[k], 20);
        end

        // Stuck high: flag 64 cycles after the valid of the last rise.
        do_reset();
        wave(3, 7);
        pwm_in = 1'b1;
        repeat (6) @(negedge clock);
        chk("sh_first_count", lg_hi.size(), 1);
        vc = (lg_cyc.size() > 0) ? lg_cyc[0] : cyc;
        guard = 0;
        while (cyc < vc + 63 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("sh_before", 32'(stuck_high), 0);
        @(negedge clock);
        chk("sh_at_64", 32'(stuck_high), 1);
        chk("sh_low_flag", 32'(stuck_low), 0);
        repeat (200 - 6 - 64) @(negedge clock);
        chk("sh_hold_high", 32'(high_cycles), 3);
        chk("sh_hold_period", 32'(period_cycles), 10);
        chk("sh_no_valid", lg_hi.size(), 1);
        pwm_in = 1'b0;
        repeat (5) @(negedge clock);
        chk("sh_cleared", 32'(stuck_high), 0);
        chk("sh_cleared_low", 32'(stuck_low), 0);
        wave(3, 7);
        chk("sh_first_rise_no_valid", lg_hi.size(), 1);
        pwm_in = 1'b1;
        repeat (6) @(negedge clock);
        pwm_in = 1'b0;
        chk("sh_resume_count", lg_hi.size(), 2);
        if (lg_hi.size() == 2) begin
            chk("sh_resume_hi", lg_hi[1], 3);
            chk("sh_resume_per", lg_per[1], 10);
        end
`endif

        // Constant low from reset: stuck_low after 65 edges, no valid.
        do_reset();
        repeat (64) @(negedge clock);
        chk("sl_before", 32'(stuck_low), 0);
        @(negedge clock);
        chk("sl_at_64", 32'(stuck_low), 1);
        chk("sl_high_flag", 32'(stuck_high), 0);
        repeat (40) @(negedge clock);
        chk("sl_no_valid", lg_hi.size(), 0);

`ifndef PWM_CAPTURE_FILTER_EN
        // Reset in the middle of a HIGH phase.
        do_reset();
        wave(3, 7);
        pwm_in = 1'b1;
        repeat (5) @(negedge clock);
        chk("mr_pre_high", 32'(high_cycles), 3);
        reset  = 1'b1;
        pwm_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk_zero("mr");
        clear_log();
        wave(3, 7);
        chk("mr_one_rise", lg_hi.size(), 0);
        pwm_in = 1'b1;
        repeat (6) @(negedge clock);
        pwm_in = 1'b0;
        chk("mr_two_rises", lg_hi.size(), 1);
        if (lg_hi.size() == 1) begin
            chk("mr_hi", lg_hi[0], 3);
            chk("mr_per", lg_per[0], 10);
        end
`endif

        // Glitchy 6/10 waveform: H4 L1 H1 L4.
        do_reset();
        repeat (3) begin
            wave(4, 1);
            wave(1, 4);
        end
        pwm_in = 1'b1;
        repeat (10) @(negedge clock);
        pwm_in = 1'b0;
`ifdef PWM_CAPTURE_FILTER_EN
        chk("gl_count", lg_hi.size(), 3);
        for (int k = 0; k < lg_hi.size() && k < 3; k++) begin
            chk($sformatf("gl_hi%0d", k), lg_hi[k], 6);
            chk($sformatf("gl_per%0d", k), lg_per[k], 10);
        end
`else
        chk("gl_count", lg_hi.size(), 6);
        if (lg_hi.size() >= 2) begin
            chk("gl_hi0", lg_hi[0], 4);
            chk("gl_per0", lg_per[0], 5);
            chk("gl_hi1", lg_hi[1], 1);
            chk("gl_per1", lg_per[1], 5);
        end
`endif

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
